// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   flush           - abandon any in-flight or held operation
//   in_valid/ready  - request handshake; ready only while idle
//   is_unsigned     - 1 = unsigned, 0 = two's-complement signed
//   use_mod         - 1 = return remainder, 0 = return quotient
//   dividend,divisor,in_tag - request payload
//   out_valid/ready - response handshake; result held until accepted
//   result, out_tag, div_zero - response payload
//   busy            - operation in flight or result pending
module div_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_unsigned,
  input  logic             use_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;     // partial remainder, always < dsr
  logic [WIDTH-1:0] dsr;     // divisor magnitude
  logic             neg_q;
  logic             neg_r;
  logic             mod_r;
  logic [WIDTH-1:0] res_r;
  logic [TAG_W-1:0] tag_r;
  logic             dz_r;

  logic             accept;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_r;
  assign out_tag   = tag_r;
  assign div_zero  = dz_r;
  assign accept    = in_valid & in_ready & ~flush;

  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude; this also yields the overflow quotient for free.
  always_comb begin
    dvd_neg = ~is_unsigned & dividend[WIDTH-1];
    dsr_neg = ~is_unsigned & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dsr_mag = dsr_neg ? -divisor : divisor;
  end

  // One restoring step: shifted needs WIDTH+1 bits since it may reach 2*dsr-1.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
    q_step  = {quo[WIDTH-2:0], ~diff[WIDTH]};
    r_step  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mod_r <= 1'b0;
      res_r <= '0;
      tag_r <= '0;
      dz_r  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tag_r <= in_tag;
            mod_r <= use_mod;
            neg_q <= dvd_neg ^ dsr_neg;
            neg_r <= dvd_neg;
            if (divisor == '0) begin
              state <= DONE;
              dz_r  <= 1'b1;
              res_r <= use_mod ? dividend : '1;
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(WIDTH);
              quo   <= dvd_mag;
              rem   <= '0;
              dsr   <= dsr_mag;
              dz_r  <= 1'b0;
            end
          end
        end
        CALC: begin
          quo <= q_step;
          rem <= r_step;
          cnt <= cnt - CNT_W'(1);
          // Sign fixup is folded into the final iteration.
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            res_r <= mod_r ? (neg_r ? -r_step : r_step)
                           : (neg_q ? -q_step : q_step);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // 32-bit instance signals
  logic        reset, flush, in_valid, is_unsigned, use_mod, out_ready;
  logic [31:0] dividend, divisor;
  logic [5:0]  in_tag;
  logic        in_ready, out_valid, div_zero, busy;
  logic [31:0] result;
  logic [5:0]  out_tag;

  // 8-bit instance signals
  logic        in_valid8, is_unsigned8, in_ready8, out_valid8, div_zero8, busy8;
  logic [7:0]  dividend8, divisor8, result8;
  logic [5:0]  out_tag8;

  div_iter #(.WIDTH(32), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_unsigned(is_unsigned), .use_mod(use_mod), .dividend(dividend), .divisor(divisor),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .div_zero(div_zero), .busy(busy)
  );

  div_iter #(.WIDTH(8), .TAG_W(6)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .is_unsigned(is_unsigned8), .use_mod(1'b0), .dividend(dividend8), .divisor(divisor8),
    .in_tag(6'h05), .out_valid(out_valid8), .out_ready(1'b1), .result(result8),
    .out_tag(out_tag8), .div_zero(div_zero8), .busy(busy8)
  );

  bit watch_ov = 1'b0;
  int ov_seen  = 0;
  always @(negedge clk) if (watch_ov && out_valid) ov_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model using native arithmetic (truncating / and dividend-signed %).
  function automatic logic [32:0] model(input int w, input bit u, input bit m,
                                       input logic [31:0] a, input logic [31:0] b);
    longint mask, as_, bs, q, r, v;
    mask = (longint'(1) << w) - 1;
    as_  = longint'(a) & mask;
    bs   = longint'(b) & mask;
    if (bs == 0) begin
      v = m ? as_ : mask;
      return {1'b1, v[31:0]};
    end
    if (!u) begin
      if (a[w-1]) as_ = as_ - (longint'(1) << w);
      if (b[w-1]) bs  = bs  - (longint'(1) << w);
    end
    q = as_ / bs;
    r = as_ % bs;
    v = (m ? r : q) & mask;
    return {1'b0, v[31:0]};
  endfunction

  task automatic do_op(input bit u, input bit m, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tg, input logic [31:0] exp_res, input bit exp_dz,
                       input int hold);
    exp_t e;
    int lat;
    bit got;
    @(negedge clk);
    check("pre_in_ready", in_ready, 1);
    in_valid = 1; is_unsigned = u; use_mod = m; dividend = a; divisor = b; in_tag = tg;
    out_ready = (hold == 0);
    sb.push_back('{res: exp_res, tag: tg, dz: exp_dz, lat: exp_dz ? 1 : 33});
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs while busy; they must be ignored.
    in_valid = 0; dividend = $urandom; divisor = $urandom; in_tag = 6'($urandom);
    is_unsigned = ~u; use_mod = ~m;
    lat = 1; got = 0;
    while (lat < 100) begin
      if (out_valid) begin got = 1; break; end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!got) check("timeout", 0, 1);
    check("latency", lat, e.lat);
    check("result", result, e.res);
    check("out_tag", out_tag, e.tag);
    check("div_zero", div_zero, e.dz);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, e.res);
      check("hold_tag", out_tag, e.tag);
    end
    out_ready = 1;
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  task automatic do_op8(input bit u, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res);
    exp_t e;
    int lat;
    bit got;
    @(negedge clk);
    in_valid8 = 1; is_unsigned8 = u; dividend8 = a; divisor8 = b;
    sb.push_back('{res: {24'd0, exp_res}, tag: 6'h05, dz: 1'b0, lat: 9});
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 0;
    lat = 1; got = 0;
    while (lat < 100) begin
      if (out_valid8) begin got = 1; break; end
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!got) check("timeout8", 0, 1);
    check("latency8", lat, e.lat);
    check("result8", {24'd0, result8}, e.res);
    check("out_tag8", out_tag8, e.tag);
    @(negedge clk);
  endtask

  initial begin
    logic [32:0] mr;
    logic [31:0] ra, rb;
    bit ru, rm;
    reset = 1; flush = 0; in_valid = 0; is_unsigned = 0; use_mod = 0; out_ready = 1;
    dividend = '0; divisor = '0; in_tag = '0;
    in_valid8 = 0; is_unsigned8 = 0; dividend8 = '0; divisor8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_div_zero", div_zero, 0);

    do_op(1, 0, 32'd100, 32'd7, 6'h01, 32'd14, 0, 0);
    do_op(1, 1, 32'd100, 32'd7, 6'h02, 32'd2, 0, 0);
    do_op(0, 0, 32'hFFFFFFF9, 32'd2, 6'h03, 32'hFFFFFFFD, 0, 0);
    do_op(0, 1, 32'hFFFFFFF9, 32'd2, 6'h04, 32'hFFFFFFFF, 0, 0);
    do_op(0, 0, 32'h80000000, 32'hFFFFFFFF, 6'h05, 32'h80000000, 0, 0);
    do_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 6'h06, 32'h0, 0, 0);
    do_op(1, 0, 32'd5, 32'd0, 6'h2A, 32'hFFFFFFFF, 1, 0);
    do_op(1, 1, 32'd5, 32'd0, 6'h2A, 32'd5, 1, 0);
    do_op(0, 0, 32'hFFFFFFF0, 32'd0, 6'h11, 32'hFFFFFFFF, 1, 0);
    do_op(1, 1, 32'd1000, 32'd33, 6'h15, 32'd10, 0, 10);

    // Flush in idle must not accept the request.
    @(negedge clk);
    in_valid = 1; flush = 1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; flush = 0;
    check("flush_idle_busy", busy, 0);
    check("flush_idle_ready", in_ready, 1);

    // Flush at T+10 of a CALC.
    watch_ov = 1; ov_seen = 0;
    @(negedge clk);
    in_valid = 1; is_unsigned = 1; use_mod = 0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    check("calc_busy", busy, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_calc_ready", in_ready, 1);
    check("flush_calc_busy", busy, 0);
    repeat (40) @(negedge clk);
    watch_ov = 0;
    check("flush_no_out_valid", ov_seen, 0);

    // Reset pulse while holding a result in DONE.
    out_ready = 0;
    in_valid = 1; is_unsigned = 1; use_mod = 1; dividend = 32'd77; divisor = 32'd0; in_tag = 6'h33;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    check("done_before_reset", out_valid, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("reset_done_ready", in_ready, 1);
    check("reset_done_result", result, 0);
    check("reset_done_tag", out_tag, 0);
    check("reset_done_dz", div_zero, 0);
    watch_ov = 1; ov_seen = 0;
    repeat (40) @(negedge clk);
    watch_ov = 0;
    check("reset_no_out_valid", ov_seen, 0);
    out_ready = 1;

    do_op(1, 0, 32'd20, 32'd3, 6'h07, 32'd6, 0, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      ru = 1'($urandom); rm = 1'($urandom);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) rb = 32'd0;
      if (i == 7) rb = 32'hFFFFFFFF;
      mr = model(32, ru, rm, ra, rb);
      do_op(ru, rm, ra, rb, 6'(i), mr[31:0], mr[32], 0);
    end

    do_op8(1, 8'hFF, 8'h10, 8'h0F);
    do_op8(0, 8'h80, 8'hFF, 8'h80);
    do_op8(0, 8'hF9, 8'h02, 8'hFD);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
